// File: rtl/pulse_fsm_decoder_if.sv
// Pulse-measurement bus: the measured pulse in, and the width/match/overflow result with its strobe out.
interface pulse_fsm_decoder_if #(
    parameter int CNT_W = 8
) ();
    logic             pulse;
    logic [CNT_W-1:0] width;
    logic             valid;
    logic             match;
    logic             overflow;

    // Source of the pulse and consumer of the measurement.
    modport master (
        output pulse,
        input  width,
        input  valid,
        input  match,
        input  overflow
    );

    // The decoder itself.
    modport slave (
        input  pulse,
        output width,
        output valid,
        output match,
        output overflow
    );
endinterface

// File: rtl/pulse_fsm_decoder.sv
// Moore FSM measuring the high time of a synchronous pulse, strobing width/match/overflow on completion.
// A level already high when reset is released is skipped until a low sample is seen.
module pulse_fsm_decoder #(
    parameter int PULSE_WIDTH = 3,
    parameter int CNT_W       = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    pulse_fsm_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PW_VAL   = CNT_W'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             ovf_acc_r;
    logic             ovf_acc_nxt_s;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] width_nxt_s;
    logic             match_r;
    logic             match_nxt_s;
    logic             overflow_r;
    logic             overflow_nxt_s;

    // Saturating increment: the counter never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // State and measurement registers; reset discards any measurement in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= WAIT_LOW;
            count_r    <= CNT_ZERO;
            ovf_acc_r  <= 1'b0;
            width_r    <= CNT_ZERO;
            match_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            ovf_acc_r  <= ovf_acc_nxt_s;
            width_r    <= width_nxt_s;
            match_r    <= match_nxt_s;
            overflow_r <= overflow_nxt_s;
        end
    end

    // Next-state and datapath decode; results are only loaded on the HIGH->DONE edge.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        ovf_acc_nxt_s  = ovf_acc_r;
        width_nxt_s    = width_r;
        match_nxt_s    = match_r;
        overflow_nxt_s = overflow_r;

        case (state_r)
            WAIT_LOW: begin
                if (!bus.pulse) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_LOW;
                end
            end

            IDLE: begin
                if (bus.pulse) begin
                    state_nxt_s   = HIGH;
                    count_nxt_s   = CNT_ONE;
                    ovf_acc_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            HIGH: begin
                if (bus.pulse) begin
                    state_nxt_s = HIGH;
                    count_nxt_s = sat_inc(count_r);
                    // A further high sample at full scale means the true width is unrepresentable.
                    if (count_r == CNT_MAX) begin
                        ovf_acc_nxt_s = 1'b1;
                    end else begin
                        ovf_acc_nxt_s = ovf_acc_r;
                    end
                end else begin
                    state_nxt_s    = DONE;
                    width_nxt_s    = count_r;
                    overflow_nxt_s = ovf_acc_r;
                    match_nxt_s    = (count_r == PW_VAL) && !ovf_acc_r;
                end
            end

            DONE: begin
                if (bus.pulse) begin
                    state_nxt_s   = HIGH;
                    count_nxt_s   = CNT_ONE;
                    ovf_acc_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            default: begin
                state_nxt_s   = WAIT_LOW;
                count_nxt_s   = CNT_ZERO;
                ovf_acc_nxt_s = 1'b0;
            end
        endcase
    end

    assign bus.valid    = (state_r == DONE);
    assign bus.width    = width_r;
    assign bus.match    = match_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_pulse_fsm_decoder.sv
// Scoreboard bench: two decoders (CNT_W=8 and CNT_W=4) share one pulse; a negedge monitor checks every cycle.
module tb_pulse_fsm_decoder;

    typedef struct {
        int         edge_no;
        logic [7:0] w;
        logic       m;
        logic       o;
    } exp_t;

    logic clock;
    logic reset_n;
    logic pulse;
    logic done;
    int   edge_cnt;
    int   chk_total;
    int   chk_pass;
    exp_t q8[$];
    exp_t q4[$];
    exp_t hold8;
    exp_t hold4;
    logic exp_v8;
    logic exp_v4;

    pulse_fsm_decoder_if #(.CNT_W(8)) bus8 ();
    pulse_fsm_decoder_if #(.CNT_W(4)) bus4 ();

    assign bus8.pulse = pulse;
    assign bus4.pulse = pulse;

    pulse_fsm_decoder #(.PULSE_WIDTH(3), .CNT_W(8)) dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus8)
    );

    pulse_fsm_decoder #(.PULSE_WIDTH(3), .CNT_W(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) begin
            chk_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // One clock: drive pulse, let the posedge sample it, settle 1 time unit.
    task automatic step(input logic v);
        pulse = v;
        @(posedge clock);
        edge_cnt++;
        #1;
    endtask

    // n sampled-high edges then one low edge; the low edge is where the strobe is expected.
    task automatic send(input int n,
                        input logic [7:0] w8, input logic m8, input logic o8,
                        input logic [7:0] w4, input logic m4, input logic o4);
        for (int i = 0; i < n; i++) step(1'b1);
        step(1'b0);
        q8.push_back('{edge_no: edge_cnt, w: w8, m: m8, o: o8});
        q4.push_back('{edge_no: edge_cnt, w: w4, m: m4, o: o4});
    endtask

    task automatic lows(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    // Monitor: valid must appear exactly on expected edges; outputs must equal the last result between strobes.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold8 = '{edge_no: 0, w: 8'd0, m: 1'b0, o: 1'b0};
            hold4 = '{edge_no: 0, w: 8'd0, m: 1'b0, o: 1'b0};
        end

        exp_v8 = (q8.size() > 0) && (q8[0].edge_no == edge_cnt);
        check("dut8 valid", 32'(bus8.valid), 32'(exp_v8));
        if (exp_v8) hold8 = q8.pop_front();
        check("dut8 width", 32'(bus8.width), 32'(hold8.w));
        check("dut8 match", 32'(bus8.match), 32'(hold8.m));
        check("dut8 overflow", 32'(bus8.overflow), 32'(hold8.o));

        exp_v4 = (q4.size() > 0) && (q4[0].edge_no == edge_cnt);
        check("dut4 valid", 32'(bus4.valid), 32'(exp_v4));
        if (exp_v4) hold4 = q4.pop_front();
        check("dut4 width", 32'(bus4.width), 32'(hold4.w));
        check("dut4 match", 32'(bus4.match), 32'(hold4.m));
        check("dut4 overflow", 32'(bus4.overflow), 32'(hold4.o));

        if (done || edge_cnt > 2000) begin
            check("cycle budget", 32'(edge_cnt > 2000), 32'd0);
            check("dut8 strobes outstanding", 32'(q8.size()), 32'd0);
            check("dut4 strobes outstanding", 32'(q4.size()), 32'd0);
            $display("%0d/%0d checks passed", chk_pass, chk_total);
            $finish;
        end
    end

    initial begin
        chk_total = 0;
        chk_pass  = 0;
        edge_cnt  = 0;
        done      = 1'b0;
        hold8     = '{edge_no: 0, w: 8'd0, m: 1'b0, o: 1'b0};
        hold4     = '{edge_no: 0, w: 8'd0, m: 1'b0, o: 1'b0};
        reset_n   = 1'b0;
        pulse     = 1'b1;

        // Level high through reset and for 6 cycles after: never measured.
        for (int i = 0; i < 3; i++) step(1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1);
        lows(2);

        // Nominal width, then a longer non-matching pulse with a hold period.
        send(3, 8'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
        lows(4);
        send(5, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0);
        lows(4);

        // Back-to-back: one low cycle between pulses.
        send(3, 8'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
        send(2, 8'd2, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
        lows(2);

        // Minimum width and the 4-bit counter boundaries.
        send(1, 8'd1, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
        lows(2);
        send(15, 8'd15, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0);
        lows(2);
        send(16, 8'd16, 1'b0, 1'b0, 8'd15, 1'b0, 1'b1);
        lows(2);
        send(20, 8'd20, 1'b0, 1'b0, 8'd15, 1'b0, 1'b1);
        lows(3);

        // Reset during the 2nd high cycle: that pulse is discarded.
        step(1'b1);
        reset_n = 1'b0;
        step(1'b1);
        reset_n = 1'b1;
        step(1'b1);
        step(1'b1);
        lows(2);
        send(3, 8'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
        lows(2);

        // Reset while in DONE: the strobe is suppressed immediately.
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        reset_n = 1'b0;
        step(1'b0);
        reset_n = 1'b1;
        lows(2);
        send(3, 8'd3, 1'b1, 1'b0, 8'd3, 1'b1, 1'b0);
        lows(3);

        done = 1'b1;
    end

endmodule
